// File: rtl/ff_modes_pkg.sv
// ff_modes_pkg: mode encodings shared by the flip-flop bank and its bench
package ff_modes_pkg;
  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_JK = 2'b10,
    MODE_SR = 2'b11
  } ff_mode_t;
endpackage

// File: rtl/ff_cell.sv
// ff_cell: one multi-mode flip-flop bit (clk, reset, en, mode, a, b, err_clr, rst_val -> q, chg, err)
module ff_cell
  import ff_modes_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  input  logic       err_clr,
  input  logic       rst_val,
  output logic       q,
  output logic       chg,
  output logic       err
);
  logic q_next;
  always_comb begin
    q_next = q;
    if (en)
      case (mode)
        MODE_D:  q_next = a;
        MODE_T:  q_next = q ^ a;
        MODE_JK: q_next = (a & ~q) | (~b & q);
        MODE_SR: q_next = (a & b) ? q : (a | (q & ~b));
        default: q_next = q;
      endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      q   <= rst_val;
      chg <= 1'b0;
      err <= 1'b0;
    end else begin
      q   <= q_next;
      chg <= q_next ^ q;
      err <= (err & ~err_clr) | (en & (mode == MODE_SR) & a & b);
    end
endmodule

// File: rtl/multi_mode_ff_bank.sv
// multi_mode_ff_bank: WIDTH-bit D/T/JK/SR flip-flop bank (clk, reset, en, mode, a, b, err_clr -> q, q_n, chg, sr_err)
module multi_mode_ff_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] chg,
  output logic [WIDTH-1:0] sr_err
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell u_cell (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .mode    (mode),
      .a       (a[i]),
      .b       (b[i]),
      .err_clr (err_clr),
      .rst_val (RESET_VAL[i]),
      .q       (q[i]),
      .chg     (chg[i]),
      .err     (sr_err[i])
    );
  end
  assign q_n = ~q;
endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// tb_multi_mode_ff_bank: directed self-checking bench for the multi-mode flip-flop bank
module tb_multi_mode_ff_bank;
  import ff_modes_pkg::*;
  logic       clk, reset, en, err_clr;
  ff_mode_t   mode;
  logic [7:0] a, b, q, q_n, chg, sr_err;
  logic       en1, clr1;
  ff_mode_t   mode1;
  logic [0:0] a1, b1, q1, qn1, chg1, err1;
  int passed = 0, total = 0;

  multi_mode_ff_bank #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
    .q(q), .q_n(q_n), .chg(chg), .sr_err(sr_err)
  );

  multi_mode_ff_bank #(.WIDTH(1), .RESET_VAL(1'b1)) dut1 (
    .clk(clk), .reset(reset), .en(en1), .mode(mode1), .a(a1), .b(b1), .err_clr(clr1),
    .q(q1), .q_n(qn1), .chg(chg1), .sr_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = MODE_D; a = '0; b = '0; err_clr = 1'b0;
    en1 = 1'b0; mode1 = MODE_T; a1 = '0; b1 = '0; clr1 = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_q", q, 8'h00);
    chk("rst_chg", chg, 8'h00);
    chk("rst_err", sr_err, 8'h00);
    chk("rst_q1", q1, 1'b1);
    step(); step();
    chk("rst_hold_q", q, 8'h00);
    reset = 1'b1; en = 1'b1; mode = MODE_SR; a = 8'h03; b = 8'h03;
    step();
    chk("pre_err", sr_err, 8'h03);
    chk("pre_q", q, 8'h00);
    mode = MODE_D; a = 8'h5A; b = 8'h00;
    step();
    chk("pre_load_q", q, 8'h5A);
    chk("pre_load_chg", chg, 8'h5A);
    #3 reset = 1'b0;
    #1;
    chk("async_q", q, 8'h00);
    chk("async_chg", chg, 8'h00);
    chk("async_err", sr_err, 8'h00);
    chk("async_q1", q1, 1'b1);
    #1 reset = 1'b1;
    a = 8'hA5;
    step();
    chk("d_q", q, 8'hA5);
    chk("d_chg", chg, 8'hA5);
    chk("d_qn", q_n, 8'h5A);
    mode = MODE_T; a = 8'h0F;
    step();
    chk("t1_q", q, 8'hAA);
    chk("t1_chg", chg, 8'h0F);
    step();
    chk("t2_q", q, 8'hA5);
    chk("t2_chg", chg, 8'h0F);
    mode = MODE_D; a = 8'h00;
    step();
    chk("clr_q", q, 8'h00);
    mode = MODE_JK; a = 8'hF0; b = 8'h3C;
    step();
    chk("jk1_q", q, 8'hF0);
    step();
    chk("jk2_q", q, 8'hC0);
    chk("jk2_chg", chg, 8'h30);
    a = 8'hFF; b = 8'hFF;
    step();
    chk("jk3_q", q, 8'h3F);
    mode = MODE_SR; a = 8'h81; b = 8'h81;
    step();
    chk("sr_bad_q", q, 8'h3F);
    chk("sr_bad_err", sr_err, 8'h81);
    chk("sr_bad_chg", chg, 8'h00);
    a = 8'h00; b = 8'h00;
    step();
    chk("sr_sticky", sr_err, 8'h81);
    err_clr = 1'b1; a = 8'h01; b = 8'h01;
    step();
    chk("sr_setwins", sr_err, 8'h01);
    a = 8'h00; b = 8'h00;
    step();
    chk("sr_cleared", sr_err, 8'h00);
    err_clr = 1'b0; a = 8'hC0; b = 8'h0F;
    step();
    chk("sr_q", q, 8'hF0);
    chk("sr_chg", chg, 8'hCF);
    en = 1'b0; mode = MODE_T; a = 8'hFF; b = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("en0_q", q, 8'hF0);
      chk("en0_chg", chg, 8'h00);
    end
    mode = MODE_SR; a = 8'hFF; b = 8'hFF;
    step();
    chk("en0_noerr", sr_err, 8'h00);
    en = 1'b1; mode = MODE_T; a = 8'hFF; b = 8'h00;
    step();
    chk("en1_q", q, 8'h0F);
    chk("en1_chg", chg, 8'hFF);
    en = 1'b0;
    step();
    chk("en1_chg_once", chg, 8'h00);
    chk("en1_hold", q, 8'h0F);
    chk("w1_start", q1, 1'b1);
    en1 = 1'b1; mode1 = MODE_T; a1 = 1'b1;
    step();
    chk("w1_q0", q1, 1'b0);
    chk("w1_qn0", qn1, 1'b1);
    step();
    chk("w1_q1", q1, 1'b1);
    chk("w1_qn1", qn1, 1'b0);
    step();
    chk("w1_q2", q1, 1'b0);
    chk("w1_qn2", qn1, 1'b1);
    chk("w1_chg", chg1, 1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
